regfile_1w_nr: RTL

Parametrised successor to the 1-write/1-read 256x64 register file: one synchronous write port and NREAD independent pipelined read ports, each using one-hot decode with an OR-reduction read instead of a mux. Adds a reset-time clear sequencer so the array holds zeros after reset, per-port read-valid tracking, and optional write-to-read bypass. Sits in the datapath wherever a multi-ported scratch or architectural register array is needed.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_rd_port.sv | 114 +++++++++++
 rtl/regfile_1w_nr.sv | 129 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// =============================================================================
//  Module      : regfile_pkg
//  Description : Shared defaults and the clear-sequencer state encoding for
//                the multi-read-port register file (regfile_1w_nr).
//  Revision    : 1.0 - initial release
// -----------------------------------------------------------------------------
//  Contents    : DEF_WIDTH / DEF_DEPTH / DEF_NREAD default parameter values,
//                seq_state_e clear-sequencer state enum.
// =============================================================================
package regfile_pkg;

   localparam int DEF_WIDTH = 64;
   localparam int DEF_DEPTH = 256;
   localparam int DEF_NREAD = 2;

   typedef enum logic [0:0] {
      SEQ_CLEAR = 1'b0,
      SEQ_READY = 1'b1
   } seq_state_e;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// =============================================================================
//  Module      : regfile_rd_port
//  Description : One three-stage read pipeline of the register file.
//                S1 registers address/request, S2 registers a one-hot decode
//                of the address, S3 registers the OR-reduction of the
//                one-hot-masked array words.
//  Revision    : 1.0 - initial release
// -----------------------------------------------------------------------------
//  Ports       : clock_i   - clock
//                reset_i   - synchronous active-high reset
//                ready_i   - array initialised; requests accepted only when 1
//                rena_i    - read request
//                raddr_i   - read address
//                wena_i    - write-port enable (bypass compare only)
//                waddr_i   - write-port address (bypass compare only)
//                wdata_i   - write-port data (bypass compare only)
//                array_i   - flattened array contents, entry i at [i*WIDTH +: WIDTH]
//                rvalid_o  - registered read-data valid
//                rdata_o   - registered read data
//  Macro       : REGFILE_BYPASS_EN - when defined, a write hitting the S2
//                address in the same cycle is forwarded into S3.
// =============================================================================
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter  int WIDTH  = DEF_WIDTH,
   parameter  int DEPTH  = DEF_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   input  logic                    ready_i,
   input  logic                    rena_i,
   input  logic [ADDR_W-1:0]       raddr_i,
   input  logic                    wena_i,
   input  logic [ADDR_W-1:0]       waddr_i,
   input  logic [WIDTH-1:0]        wdata_i,
   input  logic [DEPTH*WIDTH-1:0]  array_i,
   output logic                    rvalid_o,
   output logic [WIDTH-1:0]        rdata_o
);

   logic                s1_vld_q;
   logic [ADDR_W-1:0]   s1_addr_q;
   logic                s2_vld_q;
   logic [DEPTH-1:0]    s2_hot_q;
   logic [DEPTH-1:0]    s2_hot_d;
   logic [WIDTH-1:0]    sel_d;
   logic [WIDTH-1:0]    rdata_d;
   logic                rvalid_q;
   logic [WIDTH-1:0]    rdata_q;

   always_comb begin
      s2_hot_d            = '0;
      s2_hot_d[s1_addr_q] = 1'b1;
   end

   // AND-OR selection: exactly one hot bit, so the OR of masked words is the
   // addressed entry.
   always_comb begin
      sel_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         sel_d = sel_d | (array_i[i*WIDTH +: WIDTH] & {WIDTH{s2_hot_q[i]}});
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic [ADDR_W-1:0] s2_addr_q;
   logic              byp_hit;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         s2_addr_q <= '0;
      end else begin
         s2_addr_q <= s1_addr_q;
      end
   end

   // The write in this cycle lands in the array only at the edge, so forward
   // it to make the newest value visible to the read being sampled now.
   assign byp_hit = ready_i & wena_i & (waddr_i == s2_addr_q);
   assign rdata_d = byp_hit ? wdata_i : sel_d;
`else
   logic unused_bypass;
   assign unused_bypass = ^{wena_i, waddr_i, wdata_i};
   assign rdata_d       = sel_d;
`endif

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         s1_vld_q  <= 1'b0;
         s1_addr_q <= '0;
         s2_vld_q  <= 1'b0;
         s2_hot_q  <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         s1_vld_q  <= rena_i & ready_i;
         s1_addr_q <= raddr_i;
         s2_vld_q  <= s1_vld_q;
         s2_hot_q  <= s2_hot_d;
         rvalid_q  <= s2_vld_q;
         if (s2_vld_q) begin
            rdata_q <= rdata_d;
         end
      end
   end

   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;

endmodule : regfile_rd_port
`default_nettype wire

// File: rtl/regfile_1w_nr.sv
`default_nettype none
// =============================================================================
//  Module      : regfile_1w_nr
//  Description : DEPTH x WIDTH register file with one synchronous write port
//                and NREAD independent 3-cycle pipelined read ports. After
//                reset a clear sequencer writes zero to every entry, one per
//                cycle, before the ports are enabled.
//  Revision    : 1.0 - initial release
// -----------------------------------------------------------------------------
//  Ports       : clock_i     - clock, rising edge
//                reset_i     - synchronous active-high reset
//                rena_i      - per-port read request [NREAD]
//                raddr_i     - read addresses, port p at [p*ADDR_W +: ADDR_W]
//                wena_i      - write enable
//                waddr_i     - write address
//                wdata_i     - write data
//                init_busy_o - high while the clear sequencer runs
//                rvalid_o    - per-port registered read valid [NREAD]
//                rdata_o     - per-port registered read data, port p at
//                              [p*WIDTH +: WIDTH]
//  Macro       : REGFILE_BYPASS_EN - enables write-to-read forwarding in the
//                read ports.
// =============================================================================
module regfile_1w_nr
   import regfile_pkg::*;
#(
   parameter  int WIDTH  = DEF_WIDTH,
   parameter  int DEPTH  = DEF_DEPTH,
   parameter  int NREAD  = DEF_NREAD,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   input  logic [NREAD-1:0]        rena_i,
   input  logic [NREAD*ADDR_W-1:0] raddr_i,
   input  logic                    wena_i,
   input  logic [ADDR_W-1:0]       waddr_i,
   input  logic [WIDTH-1:0]        wdata_i,
   output logic                    init_busy_o,
   output logic [NREAD-1:0]        rvalid_o,
   output logic [NREAD*WIDTH-1:0]  rdata_o
);

   seq_state_e          state_q;
   seq_state_e          state_d;
   logic [ADDR_W-1:0]   clr_cnt_q;
   logic [ADDR_W-1:0]   clr_cnt_d;
   logic                arr_we;
   logic [ADDR_W-1:0]   arr_waddr;
   logic [WIDTH-1:0]    arr_wdata;
   logic                ready;

   logic [WIDTH-1:0]       mem_q [DEPTH];
   logic [DEPTH*WIDTH-1:0] mem_flat;

   // ---------------------------------------------------------------- sequencer
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q   <= SEQ_CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // The sequencer owns the array write port while clearing; the external
   // write port is ignored until READY.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      arr_we    = 1'b0;
      arr_waddr = waddr_i;
      arr_wdata = wdata_i;
      case (state_q)
         SEQ_CLEAR: begin
            arr_we    = 1'b1;
            arr_waddr = clr_cnt_q;
            arr_wdata = '0;
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
               state_d = SEQ_READY;
            end
         end
         SEQ_READY: begin
            arr_we = wena_i;
         end
         default: begin
            state_d = SEQ_CLEAR;
         end
      endcase
   end

   assign ready       = (state_q == SEQ_READY);
   assign init_busy_o = (state_q == SEQ_CLEAR);

   // ---------------------------------------------------------------- array
   always_ff @(posedge clock_i) begin
      if (!reset_i && arr_we) begin
         mem_q[arr_waddr] <= arr_wdata;
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign mem_flat[gi*WIDTH +: WIDTH] = mem_q[gi];
   end

   // ---------------------------------------------------------------- read ports
   for (genvar gp = 0; gp < NREAD; gp++) begin : g_rd_port
      regfile_rd_port #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_rd_port (
         .clock_i  (clock_i),
         .reset_i  (reset_i),
         .ready_i  (ready),
         .rena_i   (rena_i[gp]),
         .raddr_i  (raddr_i[gp*ADDR_W +: ADDR_W]),
         .wena_i   (wena_i),
         .waddr_i  (waddr_i),
         .wdata_i  (wdata_i),
         .array_i  (mem_flat),
         .rvalid_o (rvalid_o[gp]),
         .rdata_o  (rdata_o[gp*WIDTH +: WIDTH])
      );
   end

endmodule : regfile_1w_nr
`default_nettype wire
